// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU memory stage vs DMA/debug loader.
// Grants one side per cycle, bounds DMA starvation and steers synchronous read data back to its owner.
module dmem_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [0:0] {PRI_CPU = 1'b0, PRI_DMA = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} own_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t            state_r, state_nxt_s;
  logic [3:0]        wait_cnt, wait_cnt_nxt_s;
  own_t              rd_own_q, rd_own_nxt_s;
  logic              cpu_gnt_s, dma_gnt_s;
  logic [DATA_W-1:0] cpu_rdata_r, dma_rdata_r;

  // Grant decision, starvation counter and next state; grants are suppressed while in reset
  always_comb begin
    cpu_gnt_s      = 1'b0;
    dma_gnt_s      = 1'b0;
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt;
    rd_own_nxt_s   = OWN_NONE;
    if (!reset) begin
      case (state_r)
        PRI_CPU: begin
          cpu_gnt_s = cpu_req;
          dma_gnt_s = dma_req & ~cpu_req;
        end
        PRI_DMA: begin
          dma_gnt_s = dma_req;
          cpu_gnt_s = cpu_req & ~dma_req;
        end
        default: begin
          cpu_gnt_s = cpu_req;
          dma_gnt_s = dma_req & ~cpu_req;
        end
      endcase
    end else begin
      cpu_gnt_s = 1'b0;
    end

    if (dma_gnt_s || !dma_req) begin
      wait_cnt_nxt_s = 4'd0;
    end else if (cpu_gnt_s && (wait_cnt < MAX_WAIT_C)) begin
      wait_cnt_nxt_s = wait_cnt + 4'd1;
    end else begin
      wait_cnt_nxt_s = wait_cnt;
    end

    if (state_r == PRI_CPU) begin
      if (cpu_gnt_s && dma_req && (wait_cnt_nxt_s == MAX_WAIT_C)) begin
        state_nxt_s = PRI_DMA;
      end else begin
        state_nxt_s = PRI_CPU;
      end
    end else if (dma_gnt_s || !dma_req) begin
      state_nxt_s = PRI_CPU;
    end else begin
      state_nxt_s = PRI_DMA;
    end

    if (cpu_gnt_s && !cpu_we) begin
      rd_own_nxt_s = OWN_CPU;
    end else if (dma_gnt_s && !dma_we) begin
      rd_own_nxt_s = OWN_DMA;
    end else begin
      rd_own_nxt_s = OWN_NONE;
    end
  end

  // A read tag still in flight when reset arrives must not surface as rvalid
  assign cpu_rvalid = ~reset & (rd_own_q == OWN_CPU);
  assign dma_rvalid = ~reset & (rd_own_q == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_r;
  assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_r;

  assign cpu_stall = cpu_req & ~cpu_gnt_s & ~reset;
  assign dma_gnt   = dma_gnt_s;
  assign mem_we    = (cpu_gnt_s & cpu_we) | (dma_gnt_s & dma_we);
  assign mem_addr  = dma_gnt_s ? dma_addr  : cpu_addr;
  assign mem_wdata = dma_gnt_s ? dma_wdata : cpu_wdata;

  // State, wait counter, read-owner tag and held read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= PRI_CPU;
      wait_cnt    <= 4'd0;
      rd_own_q    <= OWN_NONE;
      cpu_rdata_r <= '0;
      dma_rdata_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      wait_cnt <= wait_cnt_nxt_s;
      rd_own_q <= rd_own_nxt_s;
      if (cpu_rvalid) begin
        cpu_rdata_r <= mem_rdata;
      end
      if (dma_rvalid) begin
        dma_rdata_r <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a starvation-count reference model plus a shadow memory
// predict grants, memory-side muxing and read return every cycle.
module tb_dmem_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] tb_mem  [256];
  logic [DW-1:0] mdl_mem [256];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model state
  int            starve;
  bit            pend_cpu, pend_dma;
  logic [DW-1:0] pend_cpu_d, pend_dma_d, last_cpu, last_dma;
  bit            hold_cpu, hold_dma;
  int            p_cpu, p_dma;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // synchronous-read single-port memory
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr[7:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
  endtask

  task automatic do_cycle(input bit rst);
    bit            dg, cg, exp_stall, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    @(negedge clk);
    cyc++;
    reset = rst;
    if (!hold_dma) begin
      dma_req   = ($urandom_range(0, 99) < p_dma);
      dma_we    = 1'($urandom_range(0, 1));
      dma_addr  = 16'($urandom_range(0, 255));
      dma_wdata = 16'($urandom);
    end
    if (!hold_cpu) begin
      cpu_req   = ($urandom_range(0, 99) < p_cpu);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom_range(0, 255));
      cpu_wdata = 16'($urandom);
    end
    #1;
    // DMA wins when the CPU is idle or has already had MAX_WAIT grants over it
    if (rst) begin
      dg = 1'b0;
      cg = 1'b0;
    end else begin
      dg = dma_req && (!cpu_req || starve >= MW);
      cg = cpu_req && !dg;
    end
    exp_stall = cpu_req && !cg && !rst;
    exp_we    = (cg && cpu_we) || (dg && dma_we);
    exp_addr  = dg ? dma_addr : cpu_addr;
    exp_wdata = dg ? dma_wdata : cpu_wdata;

    check_eq("dma_gnt", 32'(dma_gnt), 32'(dg));
    check_eq("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
    check_eq("mem_we", 32'(mem_we), 32'(exp_we));
    check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
    check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(pend_cpu && !rst));
    check_eq("dma_rvalid", 32'(dma_rvalid), 32'(pend_dma && !rst));
    if (!rst) begin
      check_eq("cpu_rdata", 32'(cpu_rdata), 32'(pend_cpu ? pend_cpu_d : last_cpu));
      check_eq("dma_rdata", 32'(dma_rdata), 32'(pend_dma ? pend_dma_d : last_dma));
    end

    if (rst) begin
      starve   = 0;
      pend_cpu = 1'b0;
      pend_dma = 1'b0;
      last_cpu = '0;
      last_dma = '0;
    end else begin
      if (pend_cpu) last_cpu = pend_cpu_d;
      if (pend_dma) last_dma = pend_dma_d;
      pend_cpu   = cg && !cpu_we;
      pend_dma   = dg && !dma_we;
      pend_cpu_d = mdl_mem[cpu_addr[7:0]];
      pend_dma_d = mdl_mem[dma_addr[7:0]];
      if (cg && cpu_we) mdl_mem[cpu_addr[7:0]] = cpu_wdata;
      if (dg && dma_we) mdl_mem[dma_addr[7:0]] = dma_wdata;
      starve = (dma_req && cg) ? starve + 1 : 0;
    end
    hold_dma = dma_req && !dg;
    hold_cpu = exp_stall;
  endtask

  initial begin
    int pc_tab [4];
    int pd_tab [4];
    pc_tab = '{100, 50, 90, 20};
    pd_tab = '{100, 50, 30, 80};
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 16'($urandom);
      mdl_mem[i] = tb_mem[i];
    end
    reset     = 1'b1;
    cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req   = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    starve    = 0;
    pend_cpu  = 1'b0; pend_dma = 1'b0;
    pend_cpu_d = '0; pend_dma_d = '0;
    last_cpu  = '0; last_dma = '0;
    hold_cpu  = 1'b0; hold_dma = 1'b0;
    p_cpu     = 0; p_dma = 0;

    do_cycle(1'b1);
    do_cycle(1'b1);
    for (int ph = 0; ph < 4; ph++) begin
      p_cpu = pc_tab[ph];
      p_dma = pd_tab[ph];
      for (int k = 0; k < 250; k++) begin
        do_cycle($urandom_range(0, 99) < 2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
